// File: rtl/dg_pkg.sv
// dg_pkg: descriptor layout, FSM states and defaults shared by dg_ctl and dg_ram.
package dg_pkg;
    localparam int DG_PKT_ID_W = 16;
    localparam int DESC_W = 27;
    typedef struct packed {
        logic [9:0] wait_num;
        logic [9:0] len;
        logic [2:0] prior;
        logic [3:0] da;
    } dg_desc_t;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, SEND} dg_state_t;
    function automatic dg_desc_t dg_unpack(input logic [DESC_W-1:0] word);
        return dg_desc_t'(word);
    endfunction
    function automatic logic [DESC_W-1:0] dg_pack(input dg_desc_t d);
        return DESC_W'(d);
    endfunction
endpackage

// File: rtl/dg_ctl.sv
// dg_ctl: fetches one descriptor at a time, idles wait cycles, then emits a len-word packet.
// Define DG_CTL_STAT_EN to add packet and stall statistics counters.
module dg_ctl
    import dg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_ID_W   = DG_PKT_ID_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    output logic                  o_fifo_ready,
    input  logic                  i_fifo_vld,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_pkt_vld,
    output logic                  o_pkt_sop,
    output logic                  o_pkt_eop,
    output logic [3:0]            o_pkt_da,
    output logic [2:0]            o_pkt_prior,
    output logic [DATA_WIDTH-1:0] o_pkt_data,
    input  logic                  i_pkt_ready,
`ifdef DG_CTL_STAT_EN
    output logic [31:0]           o_stat_pkt_cnt,
    output logic [31:0]           o_stat_stall_cnt,
`endif
    output logic                  o_busy
);
    dg_state_t state, state_nx;
    dg_desc_t desc, desc_nx;
    logic [9:0] wait_cnt, wait_cnt_nx, idx, idx_nx;
    logic [PKT_ID_W-1:0] pkt_id, pkt_id_nx;
    logic accept, fire, done;
    logic fifo_ready_nx, vld_nx, sop_nx, eop_nx, busy_nx;
    logic [3:0] da_nx;
    logic [2:0] prior_nx;
    logic [DATA_WIDTH-1:0] data_nx;
    logic unused_hi;

    assign accept = state == REQ && i_fifo_vld;
    assign fire = o_pkt_vld && i_pkt_ready;
    assign done = fire && o_pkt_eop;
    assign unused_hi = ^i_fifo_data[DATA_WIDTH-1:DESC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            desc <= '0;
            wait_cnt <= '0;
            idx <= '0;
            pkt_id <= '0;
        end else begin
            state <= state_nx;
            desc <= desc_nx;
            wait_cnt <= wait_cnt_nx;
            idx <= idx_nx;
            pkt_id <= pkt_id_nx;
        end
    end

    // An empty descriptor still consumes a packet id even though nothing is sent.
    always_comb begin
        state_nx = state;
        desc_nx = accept ? dg_unpack(i_fifo_data[DESC_W-1:0]) : desc;
        wait_cnt_nx = accept ? desc_nx.wait_num : (state == WAIT ? wait_cnt - 10'd1 : wait_cnt);
        idx_nx = accept ? '0 : (fire ? idx + 10'd1 : idx);
        pkt_id_nx = done || (accept && desc_nx.len == '0) ? pkt_id + 1'b1 : pkt_id;
        case (state)
            IDLE: state_nx = i_en ? REQ : IDLE;
            REQ: state_nx = !i_fifo_vld ? REQ : desc_nx.len == '0 ? IDLE : desc_nx.wait_num != '0 ? WAIT : SEND;
            WAIT: state_nx = wait_cnt == 10'd1 ? SEND : WAIT;
            SEND: state_nx = done ? IDLE : SEND;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are computed from the next state so that the registered bus lines up with the FSM.
    always_comb begin
        fifo_ready_nx = state == IDLE && i_en;
        vld_nx = state_nx == SEND;
        sop_nx = vld_nx && idx_nx == '0;
        eop_nx = vld_nx && idx_nx == desc_nx.len - 10'd1;
        da_nx = vld_nx ? desc_nx.da : '0;
        prior_nx = vld_nx ? desc_nx.prior : '0;
        data_nx = vld_nx ? DATA_WIDTH'({pkt_id_nx, 16'(idx_nx)}) : '0;
        busy_nx = state_nx != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_fifo_ready <= 1'b0;
            o_pkt_vld <= 1'b0;
            o_pkt_sop <= 1'b0;
            o_pkt_eop <= 1'b0;
            o_pkt_da <= '0;
            o_pkt_prior <= '0;
            o_pkt_data <= '0;
            o_busy <= 1'b0;
        end else begin
            o_fifo_ready <= fifo_ready_nx;
            o_pkt_vld <= vld_nx;
            o_pkt_sop <= sop_nx;
            o_pkt_eop <= eop_nx;
            o_pkt_da <= da_nx;
            o_pkt_prior <= prior_nx;
            o_pkt_data <= data_nx;
            o_busy <= busy_nx;
        end
    end

`ifdef DG_CTL_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_stat_pkt_cnt <= '0;
            o_stat_stall_cnt <= '0;
        end else begin
            o_stat_pkt_cnt <= done ? o_stat_pkt_cnt + 32'd1 : o_stat_pkt_cnt;
            o_stat_stall_cnt <= o_pkt_vld && !i_pkt_ready ? o_stat_stall_cnt + 32'd1 : o_stat_stall_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_dg_ctl.sv
// tb_dg_ctl: directed bench for dg_ctl with a one-cycle-latency descriptor FIFO model.
module tb_dg_ctl;
    logic clk = 0, rst_n = 0, i_en = 0, i_fifo_vld = 0, i_pkt_ready = 1;
    logic [31:0] i_fifo_data = '0;
    logic o_fifo_ready, o_pkt_vld, o_pkt_sop, o_pkt_eop, o_busy;
    logic [3:0] o_pkt_da;
    logic [2:0] o_pkt_prior;
    logic [31:0] o_pkt_data;
`ifdef DG_CTL_STAT_EN
    logic [31:0] o_stat_pkt_cnt, o_stat_stall_cnt;
`endif

    typedef struct {
        int cyc;
        logic [40:0] w;
    } xfer_t;

    logic [31:0] fifo_q[$];
    int acc_q[$];
    xfer_t xq[$];
    int cyc = 0, n_req = 0, n_stall = 0, total = 0, bad = 0;
    logic pend = 0, tog = 0, ph = 0, prev_stall = 0;
    logic [41:0] snap = '0;

    dg_ctl dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_en(i_en),
        .o_fifo_ready(o_fifo_ready),
        .i_fifo_vld(i_fifo_vld),
        .i_fifo_data(i_fifo_data),
        .o_pkt_vld(o_pkt_vld),
        .o_pkt_sop(o_pkt_sop),
        .o_pkt_eop(o_pkt_eop),
        .o_pkt_da(o_pkt_da),
        .o_pkt_prior(o_pkt_prior),
        .o_pkt_data(o_pkt_data),
        .i_pkt_ready(i_pkt_ready),
`ifdef DG_CTL_STAT_EN
        .o_stat_pkt_cnt(o_stat_pkt_cnt),
        .o_stat_stall_cnt(o_stat_stall_cnt),
`endif
        .o_busy(o_busy)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] desc(input int wt, input int len, input int pr, input int da);
        return (32'(wt) << 17) | (32'(len) << 7) | (32'(pr) << 4) | 32'(da);
    endfunction

    // FIFO answers a request pulse one cycle later; bus ready follows the 1/0 pattern when tog is set.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (prev_stall)
            chk("stall_hold", 64'({o_pkt_vld, o_pkt_sop, o_pkt_eop, o_pkt_da, o_pkt_prior, o_pkt_data}), 64'(snap));
        i_fifo_vld = 0;
        if (pend && fifo_q.size() > 0) begin
            i_fifo_vld = 1;
            i_fifo_data = fifo_q.pop_front();
            acc_q.push_back(cyc);
        end
        pend = o_fifo_ready;
        if (o_fifo_ready) n_req++;
        if (o_pkt_vld) begin
            i_pkt_ready = !tog || !ph;
            ph = !ph;
        end else begin
            i_pkt_ready = 1;
            ph = 0;
        end
        if (o_pkt_vld && i_pkt_ready)
            xq.push_back('{cyc, {o_pkt_sop, o_pkt_eop, o_pkt_da, o_pkt_prior, o_pkt_data}});
        if (o_pkt_vld && !i_pkt_ready) n_stall++;
        prev_stall = o_pkt_vld && !i_pkt_ready;
        snap = {o_pkt_vld, o_pkt_sop, o_pkt_eop, o_pkt_da, o_pkt_prior, o_pkt_data};
    end

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 0;
        i_en = 0;
        tog = 0;
        fifo_q.delete();
        acc_q.delete();
        xq.delete();
        n_req = 0;
        n_stall = 0;
        pend = 0;
        prev_stall = 0;
        repeat (3) @(negedge clk);
        #1 chk("reset_outs", 64'({o_fifo_ready, o_pkt_vld, o_pkt_sop, o_pkt_eop, o_pkt_da, o_pkt_prior, o_pkt_data, o_busy}), '0);
        rst_n = 1;
    endtask

    task automatic wait_xfers(input string tag, input int n, input int budget);
        int k = 0;
        while (xq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(xq.size()), 64'(n));
    endtask

    task automatic chk_pkt(input string tag, input int base, input int id, input int len, input int da, input int pr);
        for (int i = 0; i < len; i++)
            chk(tag, 64'(xq[base+i].w), 64'({i == 0, i == len - 1, 4'(da), 3'(pr), 16'(id), 16'(i)}));
    endtask

    initial begin
        int base, k;
        // long wait, full-rate drain
        do_reset();
        fifo_q.push_back(desc(30, 11, 1, 1));
        i_en = 1;
        wait_xfers("t1_count", 11, 400);
        chk("t1_latency", 64'(xq[0].cyc - acc_q[0]), 64'(31));
        chk_pkt("t1_word", 0, 0, 11, 1, 1);
        chk("t1_burst", 64'(xq[10].cyc - xq[0].cyc), 64'(10));
        repeat (4) @(negedge clk);
        #1 chk("t1_park", 64'({o_busy, o_pkt_vld, 16'(n_req)}), 64'({1'b1, 1'b0, 16'd2}));
        // alternating backpressure
        do_reset();
        tog = 1;
        fifo_q.push_back(desc(30, 11, 1, 1));
        i_en = 1;
        wait_xfers("t2_count", 11, 400);
        chk_pkt("t2_word", 0, 0, 11, 1, 1);
        chk("t2_stalls", 64'(n_stall), 64'(10));
        chk("t2_span", 64'(xq[10].cyc - xq[0].cyc), 64'(20));
`ifdef DG_CTL_STAT_EN
        repeat (2) @(negedge clk);
        #1 chk("t2_stat", 64'({o_stat_pkt_cnt, o_stat_stall_cnt}), 64'({32'd1, 32'd10}));
`endif
        // single word, then empty descriptor burning an id
        do_reset();
        fifo_q.push_back(desc(0, 1, 2, 3));
        fifo_q.push_back(desc(5, 0, 0, 0));
        fifo_q.push_back(desc(0, 2, 0, 4));
        i_en = 1;
        wait_xfers("t3_count", 3, 300);
        chk("t3_latency", 64'(xq[0].cyc - acc_q[0]), 64'(1));
        chk_pkt("t3_single", 0, 0, 1, 3, 2);
        chk_pkt("t3_after_empty", 1, 2, 2, 4, 0);
        chk("t3_accepts", 64'(acc_q.size()), 64'(3));
        // 16 back-to-back descriptors, junk in the ignored upper bits
        do_reset();
        for (int i = 0; i < 16; i++)
            fifo_q.push_back(desc(i % 4, i % 3 + 1, i % 8, i) | ((i % 2 == 1) ? 32'hA800_0000 : 32'h0));
        i_en = 1;
        wait_xfers("t4_count", 31, 2000);
        base = 0;
        for (int i = 0; i < 16; i++) begin
            chk_pkt("t4_pkt", base, i, i % 3 + 1, i, i % 8);
            base += i % 3 + 1;
        end
        repeat (10) @(negedge clk);
        #1 chk("t4_park", 64'({o_busy, 16'(n_req)}), 64'({1'b1, 16'd17}));
        // enable gating
        do_reset();
        fifo_q.push_back(desc(0, 2, 5, 6));
        repeat (20) @(negedge clk);
        #1 chk("t5_no_req", 64'({o_busy, 16'(n_req), 16'(xq.size())}), '0);
        i_en = 1;
        @(negedge clk);
        #1 i_en = 0;
        repeat (40) @(negedge clk);
        #1 chk("t5_one_req", 64'({o_busy, 16'(n_req), 16'(xq.size())}), 64'({1'b0, 16'd1, 16'd2}));
        chk_pkt("t5_word", 0, 0, 2, 6, 5);
        // asynchronous reset in mid packet
        do_reset();
        fifo_q.push_back(desc(0, 8, 1, 2));
        i_en = 1;
        k = 0;
        while (!(o_pkt_vld && o_pkt_data[15:0] == 16'd5) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("t6_reach_w5", 64'(o_pkt_data), 64'(5));
        #2 rst_n = 0;
        #1 chk("t6_async_clr", 64'({o_fifo_ready, o_pkt_vld, o_pkt_sop, o_pkt_eop, o_pkt_da, o_pkt_prior, o_pkt_data, o_busy}), '0);
        fifo_q.delete();
        acc_q.delete();
        xq.delete();
        pend = 0;
        n_req = 0;
        prev_stall = 0;
        fifo_q.push_back(desc(0, 3, 0, 1));
        @(negedge clk);
        #1 rst_n = 1;
        wait_xfers("t6_count", 3, 200);
        chk_pkt("t6_restart", 0, 0, 3, 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
